uart_mem_loader: RTL and testbench

Serial memory loader: receives UART 8N1 bytes on RXD and writes them, in order, as words into the LED pattern memory that the SOC sequencer reads. It is the write side of the pattern-memory path: the host streams a pattern over the serial line, and this block issues single-cycle write strobes with incrementing addresses from 0 up to DEPTH-1. It contains its own RXD synchronizer, bit-timing counter and receive state machine. It then reports completion and framing errors.

---
 rtl/uart_mem_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mem_loader
//  Purpose  : Receives UART 8N1 bytes on RXD and writes the low WIDTH bits of
//             each byte, in arrival order, into the LED pattern memory at
//             addresses 0 .. DEPTH-1. Reports completion and framing errors.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   system clock, rising edge
//    RESET      in   asynchronous active-high reset
//    RXD        in   asynchronous UART line, idles high
//    clear      in   synchronous pulse: abort frame, restart loading at 0
//    wr_en      out  one-cycle write strobe
//    wr_addr    out  write address (valid with wr_en)
//    wr_data    out  write data (valid with wr_en)
//    count      out  words written since reset/clear
//    done       out  high once count == DEPTH
//    busy       out  receiver is not idle
//    frame_err  out  sticky: a stop bit sampled 0
// ============================================================================
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 20,
  parameter int WIDTH        = 5,
  parameter int ADDR_W       = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RXD,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  // The IDLE cycle that sees rx low is offset 0 and START is entered at
  // offset 1 with the counter at 0, so the mid-start sample (offset H-1)
  // lands on counter value H-2. DATA and STOP are entered one cycle after
  // the previous sample, so every later sample is N-1 counts away.
  localparam logic [CW-1:0]   c_start_last = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0]   c_bit_last   = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] c_depth      = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // RXD synchronizer; idles high so reset must not fake a start bit
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_bit;
  logic [WIDTH-1:0]    r_data;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WIDTH-1:0]    r_wr_data;
  logic [ADDR_W:0]     r_count;
  logic                r_done;
  logic                r_busy;
  logic                r_frame_err;
  logic [ADDR_W:0]     w_count_inc;

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_data      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (clear) begin
      // A write already on the bus this cycle still lands; only the
      // count increment it would have caused is dropped.
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_wr_en     <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;

      // Count advances at the end of the strobe cycle so wr_addr equals
      // count during the strobe, and done rises together with count.
      if (r_wr_en) begin
        r_count <= w_count_inc;
        r_done  <= (w_count_inc == c_depth);
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == c_start_last) begin
            r_cnt <= '0;
            if (w_rx) begin
              // glitch shorter than half a bit: ignore it
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt <= '0;
            // LSB first; bits above WIDTH are never written to memory
            if (32'(r_bit) < WIDTH) begin
              r_data[r_bit] <= w_rx;
            end
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == c_bit_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_rx) begin
              r_frame_err <= 1'b1;
            end else if (!r_done) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_count[ADDR_W-1:0];
              r_wr_data <= r_data;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign count     = r_count;
  assign done      = r_done;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mem_loader
//  Purpose  : Directed self-checking bench for uart_mem_loader
//             (CLKS_PER_BIT = 8, DEPTH = 4, WIDTH = 5, ADDR_W = 5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  localparam int N = 8;
  localparam int H = N / 2;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD   = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [4:0] wr_data;
  logic [5:0] count;
  logic       done;
  logic       busy;
  logic       frame_err;

  uart_mem_loader #(
    .CLKS_PER_BIT (N),
    .DEPTH        (4),
    .WIDTH        (5),
    .ADDR_W       (5)
  ) u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // Every cycle with wr_en high is logged, so a stretched strobe shows up
  // as an extra entry.
  logic [4:0] q_addr[$];
  logic [4:0] q_data[$];
  int         q_cyc[$];

  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Leaves the caller 1 ns after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      RXD = fr[i];
      tick(N);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({1'b1, b, 1'b0}, 10);
  endtask

  // Stop bit held low across the receiver's sample point, then released
  // before the receiver re-arms so no new start is seen.
  task automatic send_bad_stop(input logic [7:0] b);
    send_bits({1'b0, b, 1'b0}, 9);
    RXD = 1'b0;
    tick(H);
    RXD = 1'b1;
    tick(N - H);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int base;
    logic [7:0] fill_b[4];
    logic [4:0] fill_d[4];
    fill_b = '{8'h01, 8'h12, 8'h1F, 8'hE3};
    fill_d = '{5'h01, 5'h12, 5'h1F, 5'h03};

    // ---------------- reset defaults ----------------
    tick(3);
    RESET = 1'b0;
    tick(2);
    chk("rst_wr_en",     32'(wr_en),     0);
    chk("rst_wr_addr",   32'(wr_addr),   0);
    chk("rst_wr_data",   32'(wr_data),   0);
    chk("rst_count",     32'(count),     0);
    chk("rst_done",      32'(done),      0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_frame_err", 32'(frame_err), 0);

    // first byte, with pin-to-strobe latency
    t0 = cyc;
    send_byte(8'h0C);
    tick(4);
    chk("b0C_nwr",   32'(q_addr.size()), 1);
    chk("b0C_addr",  32'(q_addr[0]), 0);
    chk("b0C_data",  32'(q_data[0]), 32'h0C);
    chk("b0C_count", 32'(count), 1);
    chk("latency_in_window",
        32'((q_cyc[0] - t0) >= (2 + H + 9 * N) && (q_cyc[0] - t0) <= (2 + H + 9 * N + 2)), 1);

    // asynchronous reset in the middle of a frame
    RXD = 1'b0;
    tick(30);
    chk("mid_busy", 32'(busy), 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_busy",    32'(busy),    0);
    chk("arst_count",   32'(count),   0);
    chk("arst_wr_data", 32'(wr_data), 0);
    chk("arst_wr_en",   32'(wr_en),   0);
    RXD = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(20);
    send_byte(8'h13);
    tick(4);
    chk("b13_nwr",   32'(q_addr.size()), 2);
    chk("b13_addr",  32'(q_addr[1]), 0);
    chk("b13_data",  32'(q_data[1]), 32'h13);
    chk("b13_count", 32'(count), 1);

    // ---------------- back-to-back fill ----------------
    pulse_clear();
    chk("clr_count", 32'(count), 0);
    base = q_addr.size();
    for (int i = 0; i < 4; i++) send_byte(fill_b[i]);
    tick(4);
    chk("fill_nwr", 32'(q_addr.size()), 32'(base + 4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_addr%0d", i), 32'(q_addr[base + i]), 32'(i));
      chk($sformatf("fill_data%0d", i), 32'(q_data[base + i]), 32'(fill_d[i]));
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_done",  32'(done),  1);

    // ---------------- overflow ----------------
    base = q_addr.size();
    send_byte(8'h05);
    tick(4);
    chk("ovf_nwr",   32'(q_addr.size()), 32'(base));
    chk("ovf_count", 32'(count), 4);
    chk("ovf_done",  32'(done),  1);

    // ---------------- bad stop bit ----------------
    pulse_clear();
    chk("clr2_done", 32'(done), 0);
    base = q_addr.size();
    send_bad_stop(8'h0A);
    tick(4);
    chk("bad_nwr",   32'(q_addr.size()), 32'(base));
    chk("bad_ferr",  32'(frame_err), 1);
    chk("bad_count", 32'(count), 0);
    chk("bad_busy",  32'(busy), 0);
    send_byte(8'h0B);
    tick(4);
    chk("b0B_nwr",   32'(q_addr.size()), 32'(base + 1));
    chk("b0B_addr",  32'(q_addr[base]), 0);
    chk("b0B_data",  32'(q_data[base]), 32'h0B);
    chk("b0B_count", 32'(count), 1);
    chk("b0B_ferr_sticky", 32'(frame_err), 1);

    // ---------------- glitch ----------------
    pulse_clear();
    chk("clr3_ferr", 32'(frame_err), 0);
    base = q_addr.size();
    RXD = 1'b0;
    tick(2);
    RXD = 1'b1;
    tick(2);
    chk("glitch_busy_hi", 32'(busy), 1);
    tick(10);
    chk("glitch_busy_lo", 32'(busy), 0);
    chk("glitch_ferr",    32'(frame_err), 0);
    chk("glitch_nwr",     32'(q_addr.size()), 32'(base));

    // ---------------- clear mid-frame ----------------
    send_bad_stop(8'h0A);
    send_byte(8'h11);
    tick(4);
    chk("pre_clr_ferr",  32'(frame_err), 1);
    chk("pre_clr_count", 32'(count), 1);
    base = q_addr.size();
    send_bits({1'b1, 8'h07, 1'b0}, 4);
    chk("b07_busy", 32'(busy), 1);
    pulse_clear();
    chk("clr4_count", 32'(count), 0);
    chk("clr4_done",  32'(done), 0);
    chk("clr4_ferr",  32'(frame_err), 0);
    chk("clr4_busy",  32'(busy), 0);
    tick(100);
    chk("clr4_nwr", 32'(q_addr.size()), 32'(base));
    send_byte(8'h09);
    tick(4);
    chk("b09_nwr",   32'(q_addr.size()), 32'(base + 1));
    chk("b09_addr",  32'(q_addr[base]), 0);
    chk("b09_data",  32'(q_data[base]), 32'h09);
    chk("b09_count", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
